// File: rtl/countdown_sequencer.sv
// M:SS countdown controller: IDLE/RUN/PAUSE/DONE with BCD borrow and a timed alarm window.
// Optional build macro COUNTDOWN_ALARM_BLINK_EN makes the alarm toggle per tick instead of holding steady.
module countdown_sequencer #(
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       start_stop,
    input  logic       clear,
    input  logic [1:0] start_minutes,
    output logic [1:0] minutes,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] ALARM_LOAD = 8'(ALARM_TICKS);

    state_t     state_q;
    logic [1:0] minutes_q;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic       running_q;
    logic       done_q;
    logic       alarm_q;
    logic [7:0] alarm_cnt_q;

    logic [1:0] minutes_d;
    logic [3:0] tens_d;
    logic [3:0] ones_d;
    logic       zero_d;

    // Value one second earlier, with BCD borrow through tens and minutes.
    always_comb begin
        minutes_d = minutes_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
        end else begin
            ones_d    = 4'd9;
            tens_d    = 4'd5;
            minutes_d = minutes_q - 2'd1;
        end
        zero_d = (minutes_d == 2'd0) && (tens_d == 4'd0) && (ones_d == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            minutes_q   <= 2'd0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 8'd0;
        end else if (clear && (state_q != IDLE)) begin
            state_q     <= IDLE;
            minutes_q   <= start_minutes;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    minutes_q <= start_minutes;
                    tens_q    <= 4'd0;
                    ones_q    <= 4'd0;
                    if (start_stop) begin
                        if (start_minutes != 2'd0) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end else begin
                            // A 0:00 start expires immediately.
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            alarm_q     <= 1'b1;
                            alarm_cnt_q <= ALARM_LOAD;
                        end
                    end
                end
                RUN: begin
                    if (tick_1hz) begin
                        minutes_q <= minutes_d;
                        tens_q    <= tens_d;
                        ones_q    <= ones_d;
                    end
                    if (tick_1hz && zero_d) begin
                        state_q     <= DONE;
                        running_q   <= 1'b0;
                        done_q      <= 1'b1;
                        alarm_q     <= 1'b1;
                        alarm_cnt_q <= ALARM_LOAD;
                    end else if (start_stop) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (start_stop) begin
                        state_q     <= IDLE;
                        done_q      <= 1'b0;
                        alarm_q     <= 1'b0;
                        alarm_cnt_q <= 8'd0;
                    end else if (tick_1hz && (alarm_cnt_q != 8'd0)) begin
                        alarm_cnt_q <= alarm_cnt_q - 8'd1;
                        if (alarm_cnt_q == 8'd1) begin
                            alarm_q <= 1'b0;
                        end else begin
`ifdef COUNTDOWN_ALARM_BLINK_EN
                            alarm_q <= ~alarm_q;
`else
                            alarm_q <= 1'b1;
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign minutes = minutes_q;
    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer: expected M:SS and flags queued on stimulus, compared after each edge.
module tb_countdown_sequencer;

    typedef logic [12:0] st_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] start_minutes = 2'd1;
    logic [1:0] minutes;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;
    logic       alarm;

    st_t   exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    countdown_sequencer #(.ALARM_TICKS(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1hz     (tick_1hz),
        .start_stop   (start_stop),
        .clear        (clear),
        .start_minutes(start_minutes),
        .minutes      (minutes),
        .tens         (tens),
        .ones         (ones),
        .running      (running),
        .done         (done),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    function automatic st_t pk(input int m, input int t, input int o,
                               input int r, input int d, input int a);
        return {m[1:0], t[3:0], o[3:0], r[0], d[0], a[0]};
    endfunction

    function automatic st_t act();
        return {minutes, tens, ones, running, done, alarm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle gap, then a one-clk tick strobe (optionally with start_stop in the same clk).
    task automatic pulse(input logic tk, input logic ss, input logic cl);
        step();
        step();
        tick_1hz   = tk;
        start_stop = ss;
        clear      = cl;
        step();
        tick_1hz   = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic test_reset();
        st_t e;
        string n;
        reset = 1'b1;
        start_minutes = 2'd1;
        step();
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0)); name_q.push_back("reset_state");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        reset = 1'b0;
        step();
        step();
        exp_q.push_back(pk(1, 0, 0, 0, 0, 0)); name_q.push_back("idle_load");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
    endtask

    task automatic test_full_count();
        st_t e;
        string n;
        pulse(1'b0, 1'b1, 1'b0);
        exp_q.push_back(pk(1, 0, 0, 1, 0, 0)); name_q.push_back("start_run");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        for (int i = 1; i <= 60; i++) begin
            int rem;
            rem = 60 - i;
            pulse(1'b1, 1'b0, 1'b0);
            exp_q.push_back(pk(rem / 60, (rem % 60) / 10, rem % 10,
                               (rem != 0) ? 1 : 0, (rem == 0) ? 1 : 0, (rem == 0) ? 1 : 0));
            name_q.push_back($sformatf("count_%0d", rem));
            e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        end
    endtask

    task automatic test_alarm_window();
        st_t e;
        string n;
        for (int k = 1; k <= 11; k++) begin
            int a;
`ifdef COUNTDOWN_ALARM_BLINK_EN
            a = (k < 10 && (k % 2) == 0) ? 1 : 0;
`else
            a = (k < 10) ? 1 : 0;
`endif
            pulse(1'b1, 1'b0, 1'b0);
            exp_q.push_back(pk(0, 0, 0, 0, 1, a));
            name_q.push_back($sformatf("alarm_tick_%0d", k));
            e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        end
        pulse(1'b0, 1'b1, 1'b0);
        step();
        exp_q.push_back(pk(1, 0, 0, 0, 0, 0)); name_q.push_back("ack_idle_reload");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
    endtask

    task automatic test_pause();
        st_t e;
        string n;
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) pulse(1'b1, 1'b0, 1'b0);
        exp_q.push_back(pk(0, 1, 0, 1, 0, 0)); name_q.push_back("at_0_10");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        pulse(1'b1, 1'b1, 1'b0);
        exp_q.push_back(pk(0, 0, 9, 0, 0, 0)); name_q.push_back("tick_and_pause");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            exp_q.push_back(pk(0, 0, 9, 0, 0, 0)); name_q.push_back($sformatf("paused_tick_%0d", i));
            e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        end
        pulse(1'b0, 1'b1, 1'b0);
        exp_q.push_back(pk(0, 0, 9, 1, 0, 0)); name_q.push_back("resume");
        pulse(1'b1, 1'b0, 1'b0);
        exp_q.push_back(pk(0, 0, 8, 1, 0, 0)); name_q.push_back("resume_tick");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (e !== pk(0, 0, 9, 1, 0, 0) || act() !== exp_q[0]) begin
            errors++; $display("FAIL %s got=%h exp=%h", n, act(), exp_q[0]);
        end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        exp_q.push_back(pk(0, 0, 8, 1, 0, 0)); name_q.push_back("pause_tick_resume_no_dec");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        exp_q.push_back(pk(0, 0, 0, 0, 1, 1)); name_q.push_back("done_beats_pause");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        pulse(1'b0, 1'b0, 1'b1);
        step();
        exp_q.push_back(pk(1, 0, 0, 0, 0, 0)); name_q.push_back("clear_from_done");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
    endtask

    task automatic test_zero_start();
        st_t e;
        string n;
        start_minutes = 2'd0;
        step();
        pulse(1'b0, 1'b1, 1'b0);
        exp_q.push_back(pk(0, 0, 0, 0, 1, 1)); name_q.push_back("zero_start_done");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        pulse(1'b0, 1'b1, 1'b0);
        step();
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0)); name_q.push_back("zero_start_ack");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
    endtask

    task automatic test_clear_and_reset();
        st_t e;
        string n;
        start_minutes = 2'd3;
        step();
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0, 1'b0);
        exp_q.push_back(pk(2, 3, 7, 1, 0, 0)); name_q.push_back("at_2_37");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        pulse(1'b0, 1'b0, 1'b1);
        step();
        exp_q.push_back(pk(3, 0, 0, 0, 0, 0)); name_q.push_back("clear_mid_run");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        start_minutes = 2'd2;
        step();
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 45; i++) pulse(1'b1, 1'b0, 1'b0);
        exp_q.push_back(pk(1, 1, 5, 1, 0, 0)); name_q.push_back("at_1_15");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0)); name_q.push_back("reset_mid_run");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
        step();
        exp_q.push_back(pk(2, 0, 0, 0, 0, 0)); name_q.push_back("reload_after_reset");
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (act() !== e) begin errors++; $display("FAIL %s got=%h exp=%h", n, act(), e); end
    endtask

    initial begin
        test_reset();
        test_full_count();
        test_alarm_window();
        test_pause();
        test_zero_start();
        test_clear_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
